// File: rtl/logic_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : logic_unit_pkg
//  Description : Shared op codes, widths and state encoding for the
//                logic_unit_pipe ALU logic group.
//  Revision    : 1.0 - initial release
// ============================================================================
package logic_unit_pkg;

    localparam int OP_W = 4;

    // Operation select codes. 8..10 are legal only when the reduction
    // feature (LOGIC_UNIT_REDUCE_EN) is built in.
    typedef enum logic [OP_W-1:0] {
        OP_NOT  = 4'd0,
        OP_AND  = 4'd1,
        OP_OR   = 4'd2,
        OP_XOR  = 4'd3,
        OP_NAND = 4'd4,
        OP_NOR  = 4'd5,
        OP_XNOR = 4'd6,
        OP_PASS = 4'd7,
        OP_RAND = 4'd8,
        OP_ROR  = 4'd9,
        OP_RXOR = 4'd10
    } op_e;

    // Output stage occupancy: EMPTY means out_valid=0, FULL means out_valid=1.
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage : logic_unit_pkg
`default_nettype wire

// File: rtl/logic_unit_core.sv
`default_nettype none
// ============================================================================
//  Module      : logic_unit_core
//  Description : Combinational op decode and bitwise compute. Produces the
//                next result and an illegal-op flag from op, a and b.
//                Macro LOGIC_UNIT_REDUCE_EN adds the reduction ops 8..10.
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 20
) (
    input  logic [OP_W-1:0]  op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             illegal_o
);

    op_e op_sel;
    assign op_sel = op_e'(op_i);

    // Decode the op and compute the result; unknown codes give zero and flag illegal.
    always_comb begin
        result_o  = '0;
        illegal_o = 1'b0;
        case (op_sel)
            OP_NOT:  result_o = ~a_i;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_NAND: result_o = ~(a_i & b_i);
            OP_NOR:  result_o = ~(a_i | b_i);
            OP_XNOR: result_o = ~(a_i ^ b_i);
            OP_PASS: result_o = a_i;
`ifdef LOGIC_UNIT_REDUCE_EN
            OP_RAND: result_o = {{(WIDTH-1){1'b0}}, &a_i};
            OP_ROR:  result_o = {{(WIDTH-1){1'b0}}, |a_i};
            OP_RXOR: result_o = {{(WIDTH-1){1'b0}}, ^a_i};
`endif
            default: begin
                result_o  = '0;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule : logic_unit_core
`default_nettype wire

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : logic_unit_pipe
//  Description : One-stage registered bitwise logic unit with valid/ready
//                handshake, zero/parity/illegal flags and a saturating
//                count of consumed results. Optional reduction ops are
//                enabled with macro LOGIC_UNIT_REDUCE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity,
    output logic             illegal,
    output logic [CNT_W-1:0] op_count
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             parity_q, parity_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, consume;

    logic_unit_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .op_i     (op),
        .a_i      (a),
        .b_i      (b),
        .result_o (result_d),
        .illegal_o(illegal_d)
    );

    // Flags are derived from the same next result so they describe the same beat.
    assign zero_d   = ~|result_d;
    assign parity_d = ^result_d;

    assign out_valid = (state_q == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    // Occupancy next-state: fill on accept, drain on consume without a refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (consume && !accept) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Occupancy register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_EMPTY;
        else     state_q <= state_d;
    end

    // Result and flags load together on accept and hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q  <= '0;
            zero_q    <= 1'b1;
            parity_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            result_q  <= result_d;
            zero_q    <= zero_d;
            parity_q  <= parity_d;
            illegal_q <= illegal_d;
        end
    end

    // Consumed-result counter sticks at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (consume && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign result   = result_q;
    assign zero     = zero_q;
    assign parity   = parity_q;
    assign illegal  = illegal_q;
    assign op_count = cnt_q;

endmodule : logic_unit_pipe
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_logic_unit_pipe
//  Description : Directed, table-driven bench for logic_unit_pipe. A second
//                instance with CNT_W=3 shares the stimulus to exercise
//                counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_pipe;

    localparam int WIDTH = 20;
    localparam int NVEC  = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [3:0]       op = 4'd0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;

    logic             in_ready, out_valid, zero, parity, illegal;
    logic [WIDTH-1:0] result;
    logic [15:0]      op_count;

    logic             s_in_ready, s_out_valid, s_zero, s_parity, s_illegal;
    logic [WIDTH-1:0] s_result;
    logic [2:0]       s_op_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic             z;
        logic             p;
        logic             ill;
    } vec_t;

    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .parity(parity), .illegal(illegal),
        .op_count(op_count)
    );

    logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(3)) u_sat (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .result(s_result), .zero(s_zero), .parity(s_parity), .illegal(s_illegal),
        .op_count(s_op_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Table: op, a, b, result, zero, parity, illegal
        vecs[0]  = '{4'd0,  20'h152AA, 20'h00000, 20'hEAD55, 1'b0, 1'b0, 1'b0}; // 12 ones -> even
        vecs[1]  = '{4'd6,  20'h152AA, 20'hFFFFF, 20'h152AA, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{4'd1,  20'h0F0F0, 20'h00F0F, 20'h00000, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{4'd2,  20'h00001, 20'h00006, 20'h00007, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{4'd3,  20'h12345, 20'h0000F, 20'h1234A, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{4'd4,  20'hFFFFF, 20'h0F0F0, 20'hF0F0F, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{4'd5,  20'hFFFFE, 20'h00000, 20'h00001, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{4'd7,  20'hABCDE, 20'h12345, 20'hABCDE, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{4'd12, 20'hFFFFF, 20'hFFFFF, 20'h00000, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{4'd15, 20'h12345, 20'h54321, 20'h00000, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{4'd0,  20'hFFFFF, 20'h00000, 20'h00000, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{4'd1,  20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 1'b0, 1'b0, 1'b0};
`ifdef LOGIC_UNIT_REDUCE_EN
        vecs[12] = '{4'd10, 20'h00007, 20'h00000, 20'h00001, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{4'd8,  20'hFFFFF, 20'h00000, 20'h00001, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{4'd9,  20'h00000, 20'hFFFFF, 20'h00000, 1'b1, 1'b0, 1'b0};
`else
        vecs[12] = '{4'd10, 20'h00007, 20'h00000, 20'h00000, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{4'd8,  20'hFFFFF, 20'h00000, 20'h00000, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{4'd9,  20'h00000, 20'hFFFFF, 20'h00000, 1'b1, 1'b0, 1'b1};
`endif

        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result",    32'(result),    32'd0);
        check("rst_zero",      32'(zero),      32'd1);
        check("rst_parity",    32'(parity),    32'd0);
        check("rst_illegal",   32'(illegal),   32'd0);
        check("rst_op_count",  32'(op_count),  32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        tick();
        rst = 1'b0;

        // Table vectors back to back: each result appears one edge after accept
        out_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            in_valid = 1'b1;
            op = vecs[i].op;
            a  = vecs[i].a;
            b  = vecs[i].b;
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
            tick();
            check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("v%0d_result", i),    32'(result),    32'(vecs[i].res));
            check($sformatf("v%0d_zero", i),      32'(zero),      32'(vecs[i].z));
            check($sformatf("v%0d_parity", i),    32'(parity),    32'(vecs[i].p));
            check($sformatf("v%0d_illegal", i),   32'(illegal),   32'(vecs[i].ill));
            check($sformatf("v%0d_op_count", i),  32'(op_count),  32'(i));
            check($sformatf("v%0d_sat_count", i), 32'(s_op_count), 32'((i > 7) ? 7 : i));
        end
        in_valid = 1'b0;
        tick();
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_op_count",  32'(op_count),  32'(NVEC));
        check("drain_result_hold", 32'(result),  32'(vecs[NVEC-1].res));

        // Backpressure: first beat held, second beat queued at the input
        in_valid = 1'b1; op = 4'd7; a = 20'h00011; b = 20'h0;
        tick();
        check("bp_first_result", 32'(result), 32'h11);
        a = 20'h00022;
        out_ready = 1'b0;
        #1;
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("bp%0d_result", i),    32'(result),    32'h11);
            check($sformatf("bp%0d_out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_in_ready", i),  32'(in_ready),  32'd0);
            check($sformatf("bp%0d_op_count", i),  32'(op_count),  32'(NVEC));
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp_second_result",    32'(result),    32'h22);
        check("bp_second_out_valid", 32'(out_valid), 32'd1);
        check("bp_second_count",     32'(op_count),  32'(NVEC + 1));
        in_valid = 1'b0;
        tick();
        check("bp_empty_out_valid", 32'(out_valid), 32'd0);
        check("bp_empty_result",    32'(result),    32'h22);
        check("bp_empty_count",     32'(op_count),  32'(NVEC + 2));
        tick();
        check("bp_idle_count",      32'(op_count),  32'(NVEC + 2));

        // Reset mid-stream while a result is waiting, between clock edges
        in_valid = 1'b1; op = 4'd0; a = 20'h00000; out_ready = 1'b0;
        tick();
        check("mr_loaded", 32'(result), 32'hFFFFF);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_result",    32'(result),    32'd0);
        check("mr_zero",      32'(zero),      32'd1);
        check("mr_op_count",  32'(op_count),  32'd0);
        check("mr_sat_count", 32'(s_op_count), 32'd0);
        tick();
        rst = 1'b0;

        // Counter saturation: 10 consumes on the 3-bit counter
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; op = 4'd3; a = 20'(i); b = 20'h0;
            tick();
            check($sformatf("sat%0d_result", i), 32'(s_result),   32'(i));
            check($sformatf("sat%0d_count", i),  32'(s_op_count), 32'((i > 7) ? 7 : i));
            check($sformatf("sat%0d_main", i),   32'(op_count),   32'(i));
        end
        in_valid = 1'b0;
        tick();
        check("sat_final_count", 32'(s_op_count), 32'd7);
        check("sat_final_main",  32'(op_count),   32'd10);
        tick();
        check("sat_hold_count",  32'(s_op_count), 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_logic_unit_pipe
`default_nettype wire
